// File: rtl/threshold_ctrl_if.sv
// Host configuration write channel for threshold_ctrl.
interface threshold_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;

  modport master (output cfg_valid, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/threshold_ctrl.sv
// Frame-synchronous threshold controller: manual or mean-derived auto thresholds, committed at frame start.
// Optional hysteresis on auto updates is enabled by defining THRESH_CTRL_HYST_EN.
module threshold_ctrl #(
  parameter int unsigned IMG_WIDTH_Y = 8,
  parameter int unsigned CNT_W       = 21,
  parameter int unsigned SUM_W       = 29
`ifdef THRESH_CTRL_HYST_EN
  , parameter int unsigned HYST      = 4
`endif
) (
  input  logic                   pixel_clk,
  input  logic                   reset,
  threshold_ctrl_if.slave        cfg,
  input  logic [IMG_WIDTH_Y-1:0] i_y,
  input  logic                   i_de,
  input  logic                   i_v_sync,
  output logic                   th_mode,
  output logic [IMG_WIDTH_Y-1:0] th1,
  output logic [IMG_WIDTH_Y-1:0] th2,
  output logic [IMG_WIDTH_Y-1:0] mean_y,
  output logic                   o_late,
  output logic                   busy
);
  localparam int unsigned YW     = IMG_WIDTH_Y;
  localparam int unsigned DW     = CNT_W + IMG_WIDTH_Y;
  localparam int unsigned CW     = (SUM_W > DW) ? SUM_W : DW;
  localparam int unsigned SW     = IMG_WIDTH_Y + 2;
  localparam int unsigned STEP_W = $clog2(IMG_WIDTH_Y);
  localparam logic [YW-1:0] Y_MAX = '1;

  typedef enum logic [1:0] {WAIT_FRAME, ACCUM, DIVIDE, ACCUM_IDLE} state_t;
  state_t state, state_nxt;

  logic              vs_q, vs_qq, rise, fall;
  logic [1:0]        ctrl_q, ctrl_eff;
  logic [7:0]        th1_q, th2_q, off_q, th1_eff, th2_eff, off_eff;
  logic              wr;
  logic [SUM_W-1:0]  acc_sum, sum_nxt, rem, rem_sub;
  logic [SUM_W:0]    sum_add;
  logic [CNT_W-1:0]  acc_cnt, cnt_nxt;
  logic [CNT_W:0]    cnt_add;
  logic [DW-1:0]     dvs;
  logic [YW-2:0]     quo;
  logic [YW-1:0]     quo_fin;
  logic [STEP_W-1:0] step;
  logic              ge, res_valid, drop, restart;
  logic              start_div, skip_div, div_last, accum_en;
  logic signed [SW-1:0] a_sum;
  logic [YW-1:0]     a_th1, a_th2;
  logic [YW:0]       a_add;
  logic              upd;

  // Flags are valid the cycle after the synchronised edge; reset to 0 so a low v_sync never fakes a frame start
  assign rise = vs_q & ~vs_qq;
  assign fall = ~vs_q & vs_qq;

  // A write landing on the commit cycle is seen by that commit
  always_comb begin
    wr       = cfg.cfg_valid & cfg.cfg_ready;
    ctrl_eff = ctrl_q;
    th1_eff  = th1_q;
    th2_eff  = th2_q;
    off_eff  = off_q;
    if (wr) begin
      case (cfg.cfg_addr)
        2'd0:    ctrl_eff = cfg.cfg_wdata[1:0];
        2'd1:    th1_eff  = cfg.cfg_wdata;
        2'd2:    th2_eff  = cfg.cfg_wdata;
        default: off_eff  = cfg.cfg_wdata;
      endcase
    end
  end

  assign accum_en = (state == ACCUM) || ((state == DIVIDE) && restart);

  always_comb begin
    sum_add = {1'b0, acc_sum} + (SUM_W+1)'(i_y);
    cnt_add = {1'b0, acc_cnt} + (CNT_W+1)'(1);
    sum_nxt = acc_sum;
    cnt_nxt = acc_cnt;
    if (accum_en && i_de) begin
      sum_nxt = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
      cnt_nxt = cnt_add[CNT_W] ? '1 : cnt_add[CNT_W-1:0];
    end
  end

  // Restoring divide step; an oversized dividend naturally yields an all-ones quotient
  always_comb begin
    ge      = CW'(rem) >= CW'(dvs);
    rem_sub = rem - SUM_W'(dvs);
    quo_fin = {quo, ge};
  end

  always_comb begin
    a_sum = $signed({2'b00, mean_y}) + $signed({{(SW-8){off_eff[7]}}, off_eff});
    if (a_sum[SW-1])      a_th1 = '0;
    else if (a_sum[YW])   a_th1 = Y_MAX;
    else                  a_th1 = a_sum[YW-1:0];
    a_add = {1'b0, a_th1} + (YW+1)'(th2_eff);
    a_th2 = a_add[YW] ? Y_MAX : a_add[YW-1:0];
  end

`ifdef THRESH_CTRL_HYST_EN
  logic [YW-1:0] a_diff;
  always_comb begin
    a_diff = (a_th1 >= th1) ? (a_th1 - th1) : (th1 - a_th1);
    upd    = a_diff > YW'(HYST);
  end
`else
  assign upd = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    start_div = 1'b0;
    skip_div  = 1'b0;
    div_last  = 1'b0;
    case (state)
      WAIT_FRAME: if (fall) state_nxt = ACCUM;
      ACCUM: begin
        if (rise) begin
          if (cnt_nxt == '0) begin
            skip_div  = 1'b1;
            state_nxt = ACCUM_IDLE;
          end else begin
            start_div = 1'b1;
            state_nxt = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (step == '0) begin
          div_last  = 1'b1;
          state_nxt = (restart || fall) ? ACCUM : ACCUM_IDLE;
        end
      end
      ACCUM_IDLE: if (fall) state_nxt = ACCUM;
      default:    state_nxt = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  always_ff @(posedge pixel_clk) begin
    cfg.cfg_ready <= 1'b1;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vs_q      <= 1'b0;
      vs_qq     <= 1'b0;
      ctrl_q    <= '0;
      th1_q     <= 8'd128;
      th2_q     <= 8'd255;
      off_q     <= '0;
      acc_sum   <= '0;
      acc_cnt   <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      step      <= '0;
      res_valid <= 1'b0;
      drop      <= 1'b0;
      restart   <= 1'b0;
      th_mode   <= 1'b0;
      th1       <= YW'(128);
      th2       <= YW'(255);
      mean_y    <= '0;
      o_late    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      vs_q   <= i_v_sync;
      vs_qq  <= vs_q;
      o_late <= 1'b0;
      ctrl_q <= ctrl_eff;
      th1_q  <= th1_eff;
      th2_q  <= th2_eff;
      off_q  <= off_eff;

      if (start_div || skip_div) begin
        acc_sum <= '0;
        acc_cnt <= '0;
      end else begin
        acc_sum <= sum_nxt;
        acc_cnt <= cnt_nxt;
      end

      if (start_div) begin
        rem       <= sum_nxt;
        dvs       <= DW'(cnt_nxt) << (YW-1);
        quo       <= '0;
        step      <= STEP_W'(YW-1);
        busy      <= 1'b1;
        res_valid <= 1'b0;
        drop      <= 1'b0;
        restart   <= 1'b0;
      end
      if (skip_div) res_valid <= 1'b1;

      // A frame starting mid-divide keeps accumulating; in auto mode the stale result is discarded
      if (state == DIVIDE) begin
        if (ge) rem <= rem_sub;
        dvs  <= dvs >> 1;
        quo  <= quo_fin[YW-2:0];
        step <= step - STEP_W'(1);
        if (fall) begin
          restart <= 1'b1;
          if (ctrl_eff[1]) drop <= 1'b1;
        end
        if (div_last) begin
          busy    <= 1'b0;
          restart <= 1'b0;
          drop    <= 1'b0;
          if (!(drop || (fall && ctrl_eff[1]))) begin
            mean_y    <= quo_fin;
            res_valid <= 1'b1;
          end
        end
      end

      if (fall) begin
        th_mode <= ctrl_eff[0];
        if (!ctrl_eff[1]) begin
          th1 <= YW'(th1_eff);
          th2 <= YW'(th2_eff);
        end else if (busy) begin
          o_late <= 1'b1;
        end else if (res_valid && upd) begin
          th1 <= a_th1;
          th2 <= a_th2;
        end
      end
    end
  end
endmodule

// File: tb/tb_threshold_ctrl.sv
// Randomised frame-level bench for threshold_ctrl against a per-frame arithmetic reference model.
module tb_threshold_ctrl;
  logic       pixel_clk = 1'b0;
  logic       reset;
  logic [7:0] i_y;
  logic       i_de, i_v_sync;
  logic       th_mode, o_late, busy;
  logic [7:0] th1, th2, mean_y;

  threshold_ctrl_if cfg ();

  threshold_ctrl dut (
    .pixel_clk(pixel_clk), .reset(reset), .cfg(cfg),
    .i_y(i_y), .i_de(i_de), .i_v_sync(i_v_sync),
    .th_mode(th_mode), .th1(th1), .th2(th2), .mean_y(mean_y),
    .o_late(o_late), .busy(busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: shadows, expected outputs and per-frame totals
  int     m_ctrl, m_th1s, m_th2s, m_off;
  int     e_mode, e_th1, e_th2, e_mean;
  int     m_res;
  bit     m_valid, m_armed, m_pend, m_late;
  longint m_sum, m_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_th1s = 128; m_th2s = 255; m_off = 0;
    e_mode = 0; e_th1 = 128; e_th2 = 255; e_mean = 0;
    m_valid = 0; m_armed = 0; m_pend = 0; m_late = 0;
    m_sum = 0; m_cnt = 0;
  endtask

  task automatic shadow_update(input int a, input int d);
    case (a)
      0:       m_ctrl = d & 3;
      1:       m_th1s = d;
      2:       m_th2s = d;
      default: m_off  = (d >= 128) ? d - 256 : d;
    endcase
  endtask

  task automatic check_reset();
    check_eq("rst_mode", th_mode, 0);
    check_eq("rst_th1", th1, 128);
    check_eq("rst_th2", th2, 255);
    check_eq("rst_mean", mean_y, 0);
    check_eq("rst_late", o_late, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cfg.cfg_ready, 1);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_addr  = 2'(a);
    cfg.cfg_wdata = 8'(d);
    tick();
    cfg.cfg_valid = 1'b0;
    shadow_update(a, d);
  endtask

  task automatic pixels(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        i_de = 1'b0;
        tick();
      end
      i_y  = 8'($urandom_range(hi, lo));
      i_de = 1'b1;
      if (m_armed) begin m_sum += i_y; m_cnt++; end
      tick();
    end
    i_de = 1'b0;
  endtask

  // Vertical blanking of 'high' cycles; 'tail' pixels overlap the v_sync rise; optional write on the commit cycle
  task automatic end_frame(input int high, input int tail, input bit wr, input int wa, input int wd);
    int a1, a2, n;
    bit upd, late_auto;
    i_v_sync = 1'b1;
    for (int t = 0; t < tail; t++) begin
      i_y  = 8'($urandom_range(255, 0));
      i_de = 1'b1;
      if (m_armed) begin m_sum += i_y; m_cnt++; end
      tick();
    end
    i_de = 1'b0;
    if (m_armed) begin
      if (m_cnt == 0) begin
        m_valid = 1; m_pend = 0;
      end else begin
        m_res = clamp8(int'(m_sum / m_cnt));
        m_pend = 1; m_valid = 0;
        m_late = (high < 9);
      end
    end
    m_sum = 0; m_cnt = 0;
    repeat (high - tail) tick();
    i_v_sync = 1'b0;
    tick();
    check_eq("hold_mode", th_mode, e_mode);
    check_eq("hold_th1", th1, e_th1);
    check_eq("hold_th2", th2, e_th2);
    if (wr) begin
      cfg.cfg_valid = 1'b1;
      cfg.cfg_addr  = 2'(wa);
      cfg.cfg_wdata = 8'(wd);
      shadow_update(wa, wd);
    end
    tick();
    cfg.cfg_valid = 1'b0;
    if (m_pend && !m_late) begin
      e_mean = m_res; m_valid = 1; m_pend = 0;
    end
    late_auto = 0;
    e_mode = m_ctrl & 1;
    if ((m_ctrl & 2) == 0) begin
      e_th1 = m_th1s; e_th2 = m_th2s;
    end else if (m_pend) begin
      late_auto = 1;
    end else if (m_valid) begin
      a1 = clamp8(e_mean + m_off);
      a2 = clamp8(a1 + m_th2s);
      upd = 1;
`ifdef THRESH_CTRL_HYST_EN
      upd = ((a1 > e_th1) ? a1 - e_th1 : e_th1 - a1) > 4;
`endif
      if (upd) begin e_th1 = a1; e_th2 = a2; end
    end
    check_eq("commit_mode", th_mode, e_mode);
    check_eq("commit_th1", th1, e_th1);
    check_eq("commit_th2", th2, e_th2);
    check_eq("commit_mean", mean_y, e_mean);
    check_eq("commit_late", o_late, int'(late_auto));
    check_eq("commit_busy", busy, int'(m_pend));
    m_armed = 1;
    tick();
    check_eq("late_width", o_late, 0);
    if (m_pend) begin
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      check_eq("busy_drop", busy, 0);
      if (!late_auto) begin e_mean = m_res; m_valid = 1; end
      check_eq("late_mean", mean_y, e_mean);
      m_pend = 0;
    end
  endtask

  initial begin
    reset = 1'b1; i_v_sync = 1'b1; i_de = 1'b0; i_y = '0;
    cfg.cfg_valid = 1'b0; cfg.cfg_addr = '0; cfg.cfg_wdata = '0;
    model_reset();
    repeat (3) tick();
    check_reset();
    reset = 1'b0;
    tick();

    // First auto frame: mean 100, offset +10, band 20
    cfg_write(0, 2); cfg_write(3, 10); cfg_write(2, 20);
    end_frame(16, 0, 0, 0, 0);
    pixels(16, 100, 100);
    end_frame(16, 0, 0, 0, 0);

    // Manual thresholds written mid-frame
    pixels(5, 0, 255);
    cfg_write(1, 50); cfg_write(2, 200); cfg_write(0, 1);
    pixels(5, 0, 255);
    end_frame(16, 0, 0, 0, 0);

    // Clamping at both ends
    cfg_write(0, 2); cfg_write(3, 20); cfg_write(2, 40);
    pixels(12, 250, 250);
    end_frame(16, 0, 0, 0, 0);
    cfg_write(3, 8'hEC);
    pixels(12, 5, 5);
    end_frame(16, 0, 0, 0, 0);

    // Short blanking: divider misses the commit, then a normal frame
    pixels(10, 60, 90);
    end_frame(4, 0, 0, 0, 0);
    pixels(10, 60, 90);
    end_frame(16, 0, 0, 0, 0);

    // Frame with no active pixels
    end_frame(16, 0, 0, 0, 0);

    // Write on the commit cycle and pixels overlapping the v_sync rise
    cfg_write(0, 1);
    pixels(8, 0, 255);
    end_frame(16, 2, 1, 1, 77);
    cfg_write(0, 2);
    pixels(6, 30, 30);
    end_frame(16, 2, 1, 3, 5);

    // Small then large mean shift
    cfg_write(3, 0); cfg_write(2, 20);
    pixels(16, 100, 100); end_frame(16, 0, 0, 0, 0);
    pixels(16, 103, 103); end_frame(16, 0, 0, 0, 0);
    pixels(16, 110, 110); end_frame(16, 0, 0, 0, 0);

    for (int f = 0; f < 12; f++) begin
      int lo, hi;
      lo = $urandom_range(200, 0);
      hi = $urandom_range(255, lo);
      pixels($urandom_range(20, 0), lo, hi);
      if ($urandom_range(1, 0) == 1) cfg_write($urandom_range(3, 0), $urandom_range(255, 0));
      pixels($urandom_range(20, 4), lo, hi);
      end_frame(($urandom_range(4, 0) == 0) ? 4 : $urandom_range(24, 16), $urandom_range(2, 0),
                1'($urandom_range(1, 0)), $urandom_range(3, 0), $urandom_range(255, 0));
    end

    // Reset in the middle of a frame; the partial frame must not be accumulated
    pixels(6, 200, 220);
    reset = 1'b1;
    tick(); tick();
    check_reset();
    model_reset();
    reset = 1'b0;
    pixels(6, 200, 220);
    end_frame(16, 0, 0, 0, 0);
    cfg_write(0, 2);
    pixels(10, 40, 40);
    end_frame(16, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
